// File: rtl/core_ctrl_pkg.sv
// Shared types and constants for the Reg_Imm_Mem core control sequencer.
package core_ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    MEM    = 3'd2,
    WB     = 3'd3,
    RETIRE = 3'd4,
    HALT   = 3'd5,
    TRAP   = 3'd6
  } state_t;

  localparam logic [6:0] OPC_R  = 7'b0110011;
  localparam logic [6:0] OPC_I  = 7'b0010011;
  localparam logic [6:0] OPC_LW = 7'b0000011;
  localparam logic [6:0] OPC_SW = 7'b0100011;

  localparam logic [1:0] TRAP_NONE     = 2'b00;
  localparam logic [1:0] TRAP_ILLEGAL  = 2'b01;
  localparam logic [1:0] TRAP_IMEM_TMO = 2'b10;
  localparam logic [1:0] TRAP_DMEM_TMO = 2'b11;

  function automatic logic is_mem_opc(input logic [6:0] opc);
    return (opc == OPC_LW) || (opc == OPC_SW);
  endfunction

endpackage

// File: rtl/core_ctrl_tmo_cnt.sv
// Wait-cycle counter with an expiry flag; cleared while no memory wait is in progress.
module ctrl_tmo_cnt #(
  parameter int MEM_TMO = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [7:0] TMO_VAL = 8'(MEM_TMO);

  logic [7:0] cnt_r;

  // Count waiting cycles, holding at the limit until cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= 8'd0;
    end else if (clr) begin
      cnt_r <= 8'd0;
    end else if (en && !expired) begin
      cnt_r <= cnt_r + 8'd1;
    end
  end

  assign expired = (cnt_r == TMO_VAL);

endmodule

// File: rtl/core_ctrl_fsm.sv
// Multi-cycle sequencer: fetch, decode, data access, write-back and retire, with
// halt handling and sticky traps for illegal opcodes and memory timeouts.
module core_ctrl_fsm
  import core_ctrl_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}},
  parameter int              MEM_TMO  = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            halt_req,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instr,
  output logic            instr_valid,
  input  logic            dec_reg_write,
  input  logic            dec_mem_read,
  input  logic            dec_mem_write,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_ack,
  output logic            rf_we,
  output logic [PC_W-1:0] pc,
  output logic [31:0]     retired,
  output logic            halted,
  output logic            trap,
  output logic [1:0]      trap_cause
);

  localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

  state_t          state_r;
  logic [PC_W-1:0] pc_r;
  logic [31:0]     instr_r;
  logic [31:0]     retired_r;
  logic            imem_req_r;
  logic            instr_valid_r;
  logic            dmem_req_r;
  logic            dmem_we_r;
  logic            rf_we_r;
  logic            halted_r;
  logic            trap_r;
  logic [1:0]      trap_cause_r;
  logic            tmo_clr_s;
  logic            tmo_en_s;
  logic            tmo_exp_s;

  // Timeout counter runs only while a fetch or data access is outstanding
  always_comb begin
    tmo_clr_s = 1'b1;
    tmo_en_s  = 1'b0;
    if (state_r == FETCH) begin
      tmo_clr_s = 1'b0;
      tmo_en_s  = !(imem_req_r && imem_ack);
    end else if (state_r == MEM) begin
      tmo_clr_s = 1'b0;
      tmo_en_s  = !(dmem_req_r && dmem_ack);
    end else begin
      tmo_clr_s = 1'b1;
      tmo_en_s  = 1'b0;
    end
  end

  ctrl_tmo_cnt #(.MEM_TMO(MEM_TMO)) u_tmo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (tmo_clr_s),
    .en      (tmo_en_s),
    .expired (tmo_exp_s)
  );

  // Main sequencer with registered control outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= FETCH;
      pc_r          <= RESET_PC;
      instr_r       <= 32'd0;
      retired_r     <= 32'd0;
      imem_req_r    <= 1'b0;
      instr_valid_r <= 1'b0;
      dmem_req_r    <= 1'b0;
      dmem_we_r     <= 1'b0;
      rf_we_r       <= 1'b0;
      halted_r      <= 1'b0;
      trap_r        <= 1'b0;
      trap_cause_r  <= TRAP_NONE;
    end else begin
      case (state_r)
        FETCH: begin
          // halt is only honoured before the request goes out
          if (!imem_req_r) begin
            if (halt_req) begin
              state_r  <= HALT;
              halted_r <= 1'b1;
            end else begin
              imem_req_r <= 1'b1;
            end
          end else if (imem_ack) begin
            instr_r       <= imem_rdata;
            imem_req_r    <= 1'b0;
            instr_valid_r <= 1'b1;
            state_r       <= DECODE;
          end else if (tmo_exp_s) begin
            imem_req_r   <= 1'b0;
            halted_r     <= 1'b1;
            trap_r       <= 1'b1;
            trap_cause_r <= TRAP_IMEM_TMO;
            state_r      <= TRAP;
          end
        end
        DECODE: begin
          if (is_mem_opc(instr_r[6:0])) begin
            state_r <= MEM;
          end else if ((instr_r[6:0] == OPC_R) || (instr_r[6:0] == OPC_I)) begin
            rf_we_r <= dec_reg_write;
            state_r <= WB;
          end else begin
            instr_valid_r <= 1'b0;
            halted_r      <= 1'b1;
            trap_r        <= 1'b1;
            trap_cause_r  <= TRAP_ILLEGAL;
            state_r       <= TRAP;
          end
        end
        MEM: begin
          if (!dmem_req_r) begin
            dmem_req_r <= 1'b1;
            // a decode claiming both read and write is treated as a load
            dmem_we_r  <= dec_mem_write && !dec_mem_read;
          end else if (dmem_ack) begin
            dmem_req_r <= 1'b0;
            dmem_we_r  <= 1'b0;
            if (dmem_we_r) begin
              instr_valid_r <= 1'b0;
              state_r       <= RETIRE;
            end else begin
              rf_we_r <= dec_reg_write;
              state_r <= WB;
            end
          end else if (tmo_exp_s) begin
            dmem_req_r    <= 1'b0;
            dmem_we_r     <= 1'b0;
            instr_valid_r <= 1'b0;
            halted_r      <= 1'b1;
            trap_r        <= 1'b1;
            trap_cause_r  <= TRAP_DMEM_TMO;
            state_r       <= TRAP;
          end
        end
        WB: begin
          rf_we_r       <= 1'b0;
          instr_valid_r <= 1'b0;
          state_r       <= RETIRE;
        end
        RETIRE: begin
          pc_r      <= pc_r + PC_STEP;
          retired_r <= retired_r + 32'd1;
          state_r   <= FETCH;
        end
        HALT: begin
          if (!halt_req) begin
            halted_r <= 1'b0;
            state_r  <= FETCH;
          end
        end
        TRAP: begin
          state_r <= TRAP;
        end
        default: begin
          imem_req_r    <= 1'b0;
          dmem_req_r    <= 1'b0;
          dmem_we_r     <= 1'b0;
          rf_we_r       <= 1'b0;
          instr_valid_r <= 1'b0;
          halted_r      <= 1'b1;
          trap_r        <= 1'b1;
          trap_cause_r  <= TRAP_ILLEGAL;
          state_r       <= TRAP;
        end
      endcase
    end
  end

  assign imem_req    = imem_req_r;
  assign imem_addr   = pc_r;
  assign instr       = instr_r;
  assign instr_valid = instr_valid_r;
  assign dmem_req    = dmem_req_r;
  assign dmem_we     = dmem_we_r;
  assign rf_we       = rf_we_r;
  assign pc          = pc_r;
  assign retired     = retired_r;
  assign halted      = halted_r;
  assign trap        = trap_r;
  assign trap_cause  = trap_cause_r;

endmodule

// File: tb/tb_core_ctrl_fsm.sv
// Randomised bench for core_ctrl_fsm: per-instruction outcomes predicted from the
// instruction-level timing and trap rules, with memory responders of variable latency.
module tb_core_ctrl_fsm;

  localparam int          TMO      = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [6:0]  OP_R  = 7'b0110011;
  localparam logic [6:0]  OP_I  = 7'b0010011;
  localparam logic [6:0]  OP_LW = 7'b0000011;
  localparam logic [6:0]  OP_SW = 7'b0100011;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        halt_req = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] instr;
  logic        instr_valid;
  logic        dec_reg_write, dec_mem_read, dec_mem_write;
  logic        dmem_req, dmem_we;
  logic        dmem_ack = 1'b0;
  logic        rf_we;
  logic [31:0] pc, retired;
  logic        halted, trap;
  logic [1:0]  trap_cause;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] pc_m;
  logic [31:0] ret_m;

  core_ctrl_fsm #(.PC_W(32), .RESET_PC(RESET_PC), .MEM_TMO(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .halt_req(halt_req),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid),
    .dec_reg_write(dec_reg_write), .dec_mem_read(dec_mem_read), .dec_mem_write(dec_mem_write),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack), .rf_we(rf_we),
    .pc(pc), .retired(retired), .halted(halted), .trap(trap), .trap_cause(trap_cause)
  );

  always #5 clk = ~clk;

  // Combinational decoder standing in for the real one
  always_comb begin
    dec_reg_write = (instr[6:0] == OP_R) || (instr[6:0] == OP_I) || (instr[6:0] == OP_LW);
    dec_mem_read  = (instr[6:0] == OP_LW);
    dec_mem_write = (instr[6:0] == OP_SW);
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0; halt_req = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    #1;
    check_eq("rst_ctl", {imem_req, instr_valid, dmem_req, dmem_we, rf_we, halted, trap, trap_cause}, 64'd0);
    check_eq("rst_pc", pc, RESET_PC);
    check_eq("rst_retired", retired, 64'd0);
    check_eq("rst_instr", instr, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pc_m  = RESET_PC;
    ret_m = 32'd0;
  endtask

  // li/ld: the ack arrives in the li-th/ld-th cycle that the request is high
  task automatic run_instr(input logic [31:0] word, input int li, input int ld,
                           input int halt_at, input bit stop_at_mem);
    int cyc, ireq_n, dreq_n, rf_n, exp_cyc, exp_dreq, exp_rf, quiet;
    logic we_seen;
    logic [1:0] exp_cause;
    logic [6:0] opc;
    logic [31:0] ret0;
    bit legal, is_mem, is_store, writes;
    opc      = word[6:0];
    is_mem   = (opc == OP_LW) || (opc == OP_SW);
    is_store = (opc == OP_SW);
    legal    = is_mem || (opc == OP_R) || (opc == OP_I);
    writes   = legal && !is_store;
    cyc = 0; ireq_n = 0; dreq_n = 0; rf_n = 0; we_seen = 1'b0;
    ret0 = retired;
    imem_rdata = word;
    while (cyc < 300) begin
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
      if (stop_at_mem && dmem_req) break;
      if (imem_req) begin ireq_n++; imem_ack = (ireq_n == li); end
      if (dmem_req) begin dreq_n++; dmem_ack = (dreq_n == ld); we_seen = dmem_we; end
      if (rf_we) rf_n++;
      if (cyc == halt_at) halt_req = 1'b1;
      @(negedge clk);
      cyc++;
      if ((retired != ret0) || halted) break;
    end
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    if (stop_at_mem) begin
      check_eq("mem_reached", dmem_req, 64'd1);
      return;
    end

    if (li > TMO) begin
      exp_cause = 2'b10; exp_cyc = TMO + 1;
    end else if (!legal) begin
      exp_cause = 2'b01; exp_cyc = li + 2;
    end else if (is_mem && ld > TMO) begin
      exp_cause = 2'b11; exp_cyc = li + TMO + 3;
    end else begin
      exp_cause = 2'b00;
      exp_cyc = li + 4 + (is_mem ? ld + 1 : 0) - (is_store ? 1 : 0);
    end
    exp_dreq = (li <= TMO && legal && is_mem) ? ((ld > TMO) ? TMO : ld) : 0;
    exp_rf   = (exp_cause == 2'b00 && writes) ? 1 : 0;
    if (exp_cause == 2'b00) begin
      pc_m  = pc_m + 32'd4;
      ret_m = ret_m + 32'd1;
    end

    check_eq("cycles", cyc, exp_cyc);
    check_eq("rf_we_pulses", rf_n, exp_rf);
    check_eq("dmem_req_cycles", dreq_n, exp_dreq);
    if (exp_dreq > 0) check_eq("dmem_we", we_seen, is_store);
    check_eq("halted", halted, exp_cause != 2'b00);
    check_eq("trap", trap, exp_cause != 2'b00);
    check_eq("trap_cause", trap_cause, exp_cause);
    check_eq("pc", pc, pc_m);
    check_eq("imem_addr", imem_addr, pc_m);
    check_eq("retired", retired, ret_m);
    if (exp_cause == 2'b00) check_eq("instr", instr, word);

    if (exp_cause != 2'b00) begin
      quiet = 0;
      for (int k = 0; k < 6; k++) begin
        imem_ack = 1'b1;
        dmem_ack = 1'b1;
        @(negedge clk);
        if (imem_req || dmem_req || rf_we || instr_valid || !halted || !trap) quiet++;
      end
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
      check_eq("trap_quiet", quiet, 64'd0);
      check_eq("trap_pc_held", pc, pc_m);
      do_reset();
    end
  endtask

  initial begin
    int bad, r, li, ld;
    logic [31:0] w;
    logic [6:0] ill_ops [4];
    ill_ops[0] = 7'h7F; ill_ops[1] = 7'b1100011; ill_ops[2] = 7'h00; ill_ops[3] = 7'b0110111;
    pc_m = RESET_PC; ret_m = 32'd0;

    do_reset();
    run_instr(32'h0050_0093, 1, 1, -1, 1'b0);   // ADDI x1,x0,5
    run_instr(32'h0000_A103, 1, 3, -1, 1'b0);   // LW
    run_instr(32'h0020_A023, 1, 1, -1, 1'b0);   // SW
    run_instr(32'h0000_0033, 2, 1, -1, 1'b0);   // R-type, slower fetch
    run_instr(32'h0000_007F, 1, 1, -1, 1'b0);   // illegal
    run_instr(32'h0050_0093, 1000, 1, -1, 1'b0);  // fetch never acknowledged
    run_instr(32'h0050_0093, TMO, 1, -1, 1'b0);   // ack on the limit cycle
    run_instr(32'h0000_A103, 1, TMO, -1, 1'b0);
    run_instr(32'h0000_A103, 1, TMO + 1, -1, 1'b0);

    // halt requested mid-load: load retires, then the core parks without fetching
    run_instr(32'h0000_A103, 1, 2, 2, 1'b0);
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (imem_req || !halted) bad++;
    end
    check_eq("halt_no_req", bad, 64'd0);
    check_eq("halt_pc", pc, pc_m);
    halt_req = 1'b0;
    @(negedge clk);
    check_eq("halt_release", halted, 64'd0);
    run_instr(32'h0050_0093, 1, 1, -1, 1'b0);

    // reset while a load is waiting on data memory
    run_instr(32'h0000_A103, 1, 50, -1, 1'b1);
    do_reset();
    run_instr(32'h0050_0093, 1, 1, -1, 1'b0);

    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      w = $urandom();
      if (r < 3)      w[6:0] = OP_R;
      else if (r < 5) w[6:0] = OP_I;
      else if (r < 7) w[6:0] = OP_LW;
      else if (r < 9) w[6:0] = OP_SW;
      else            w[6:0] = ill_ops[$urandom_range(0, 3)];
      li = ($urandom_range(0, 9) == 0) ? TMO + 1 : $urandom_range(1, TMO);
      ld = ($urandom_range(0, 7) == 0) ? TMO + 1 : $urandom_range(1, TMO);
      run_instr(w, li, ld, -1, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
